// File: rtl/fifo_shift_ram_pkg.sv
// -----------------------------------------------------------------------------
// fifo_shift_ram_pkg
// Shared constants and types for the fifo shift RAM controller: level count,
// RAM address width, occupancy width and the per-level window tables
// (base address and depth = 17*(level+1)) that carve the 2048-entry RAM into
// 11 circular buffers.
// -----------------------------------------------------------------------------
package fifo_shift_ram_pkg;

  localparam int N_LEVELS = 11;
  localparam int ADDR_W   = 11;
  localparam int OCC_W    = 8;   // holds the largest depth, 187
  localparam int SEL_W    = 4;

  typedef logic [N_LEVELS-1:0] lvl_vec_t;
  typedef logic [ADDR_W-1:0]   ram_addr_t;
  typedef logic [OCC_W-1:0]    occ_t;

  localparam ram_addr_t LVL_BASE [N_LEVELS] = '{
    11'd0,   11'd64,  11'd128, 11'd256,  11'd384,  11'd512,
    11'd640, 11'd768, 11'd1024, 11'd1280, 11'd1536
  };

  localparam occ_t LVL_DEPTH [N_LEVELS] = '{
    8'd17,  8'd34,  8'd51,  8'd68,  8'd85, 8'd102,
    8'd119, 8'd136, 8'd153, 8'd170, 8'd187
  };

  // Last address of a level's window; pointers wrap from here back to base.
  function automatic ram_addr_t lvl_last(input int lvl);
    return LVL_BASE[lvl] + ram_addr_t'(LVL_DEPTH[lvl]) - ram_addr_t'(1);
  endfunction

endpackage

// File: rtl/fsr_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fsr_rr_arbiter
// N-way round-robin arbiter. The search starts at rr_ptr; after a grant to
// requester i the pointer moves to (i+1) mod N so i becomes lowest priority.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (rr_ptr -> 0)
//   req [N]      : requests (already qualified by the caller)
//   gnt [N]      : combinational one-hot-or-zero grant
// -----------------------------------------------------------------------------
module fsr_rr_arbiter #(
  parameter int N = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             any_gnt;

  function automatic int wrap(input int a);
    return (a >= N) ? a - N : a;
  endfunction

  // NOTE: every variable written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_gnt && req[wrap(int'(rr_ptr) + k)]) begin
        gnt[wrap(int'(rr_ptr) + k)] = 1'b1;
        gnt_idx                     = PTR_W'(wrap(int'(rr_ptr) + k));
        any_gnt                     = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_shift_ram_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_shift_ram_ctrl
// Address sequencer and write arbiter for the 11-level fifo shift RAM
// (2048 x 8, port A write, port B read). Each level is a circular buffer in a
// fixed window; one arbitrated write and one selected read per cycle.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   wr_req / wr_gnt   : per-level write request, combinational one-hot grant
//   rd_req, rd_sel    : read request for level rd_sel (11..15 illegal)
//   rd_ack            : combinational read acceptance
//   flush             : per-level synchronous clear (beats any request)
//   full, empty       : per-level occupancy flags
//   ram_we/push/addra : registered port-A write strobe, level one-hot, address
//   ram_re/addrb      : registered port-B read strobe, address
// Optional build macro FIFO_SHIFT_RAM_CTRL_ERR_EN adds err_sticky[2:0]:
//   bit0 wr_req while full, bit1 rd_req while empty, bit2 rd_sel >= 11.
// -----------------------------------------------------------------------------
module fifo_shift_ram_ctrl
  import fifo_shift_ram_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  lvl_vec_t         wr_req,
  output lvl_vec_t         wr_gnt,
  input  logic             rd_req,
  input  logic [SEL_W-1:0] rd_sel,
  output logic             rd_ack,
  input  lvl_vec_t         flush,
  output lvl_vec_t         full,
  output lvl_vec_t         empty,
  output logic             ram_we,
  output lvl_vec_t         push,
  output ram_addr_t        addra,
  output logic             ram_re,
  output ram_addr_t        addrb
`ifdef FIFO_SHIFT_RAM_CTRL_ERR_EN
  ,
  output logic [2:0]       err_sticky
`endif
);

  lvl_vec_t  eligible, gnt, rd_acc, full_v, empty_v;
  ram_addr_t wr_ptr [N_LEVELS];
  ram_addr_t rd_ptr [N_LEVELS];
  ram_addr_t wr_addr_d, rd_addr_d;
  logic      sel_ok, rd_ack_c;

  // A full or flushing level must not win arbitration, so the arbiter only
  // sees qualified requests and its pointer never advances on a dead grant.
  assign eligible = wr_req & ~full_v & ~flush;

  fsr_rr_arbiter #(.N(N_LEVELS)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (eligible),
    .gnt     (gnt)
  );

  assign sel_ok = (rd_sel < SEL_W'(N_LEVELS));

  always_comb begin
    rd_ack_c = 1'b0;
    if (rd_req && sel_ok) rd_ack_c = !empty_v[rd_sel] && !flush[rd_sel];
  end

  for (genvar g = 0; g < N_LEVELS; g++) begin : g_lvl
    localparam ram_addr_t BASE  = LVL_BASE[g];
    localparam ram_addr_t LAST  = lvl_last(g);
    localparam occ_t      DEPTH = LVL_DEPTH[g];

    ram_addr_t wr_q, rd_q;
    occ_t      occ_q;

    assign rd_acc[g] = rd_ack_c && (rd_sel == SEL_W'(g));

    // Pointers and occupancy are plain registers (not RAM contents), so they
    // all take their base/zero value on reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_q  <= BASE;
        rd_q  <= BASE;
        occ_q <= '0;
      end else if (flush[g]) begin
        wr_q  <= BASE;
        rd_q  <= BASE;
        occ_q <= '0;
      end else begin
        if (gnt[g])    wr_q <= (wr_q == LAST) ? BASE : wr_q + ram_addr_t'(1);
        if (rd_acc[g]) rd_q <= (rd_q == LAST) ? BASE : rd_q + ram_addr_t'(1);
        case ({gnt[g], rd_acc[g]})
          2'b10:   occ_q <= occ_q + occ_t'(1);
          2'b01:   occ_q <= occ_q - occ_t'(1);
          default: occ_q <= occ_q;   // idle, or write+read cancel out
        endcase
      end
    end

    assign full_v[g]  = (occ_q == DEPTH);
    assign empty_v[g] = (occ_q == '0);
    assign wr_ptr[g]  = wr_q;
    assign rd_ptr[g]  = rd_q;
  end

  // One-hot select vectors make an AND-OR mux sufficient.
  always_comb begin
    wr_addr_d = '0;
    rd_addr_d = '0;
    for (int i = 0; i < N_LEVELS; i++) begin
      if (gnt[i])    wr_addr_d = wr_addr_d | wr_ptr[i];
      if (rd_acc[i]) rd_addr_d = rd_addr_d | rd_ptr[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we <= 1'b0;
      push   <= '0;
      addra  <= '0;
      ram_re <= 1'b0;
      addrb  <= '0;
    end else begin
      ram_we <= |gnt;
      push   <= gnt;
      if (|gnt) addra <= wr_addr_d;
      ram_re <= rd_ack_c;
      if (rd_ack_c) addrb <= rd_addr_d;
    end
  end

  assign wr_gnt = gnt;
  assign rd_ack = rd_ack_c;
  assign full   = full_v;
  assign empty  = empty_v;

`ifdef FIFO_SHIFT_RAM_CTRL_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= err_sticky | {rd_req && !sel_ok,
                                  rd_req && sel_ok && empty_v[rd_sel],
                                  |(wr_req & full_v)};
    end
  end
`endif

endmodule
